// File: rtl/lap_recorder_pkg.sv
// lap_recorder_pkg: shared mode encodings, lap record type and index width
package lap_recorder_pkg;
  localparam int IDX_W = 4;
  typedef enum logic [1:0] {LIVE = 2'b00, HOLD = 2'b01, RECALL = 2'b10} mode_t;
  typedef struct packed {
    logic [7:0] min;
    logic [7:0] sec;
    logic [7:0] ms_10;
  } lap_t;
endpackage

// File: rtl/lap_recorder_btn_pulse.sv
// btn_pulse: one-cycle pulse on a 0->1 button transition, no pulse if held through reset
module btn_pulse (
  input  logic clk_core,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);
  logic prev_q;
  always_ff @(posedge clk_core or negedge rst)
    if (!rst) prev_q <= 1'b1;
    else      prev_q <= btn_i;
  assign pulse_o = btn_i & ~prev_q;
endmodule

// File: rtl/lap_recorder.sv
// lap_recorder: captures stopwatch splits into a lap memory and selects live, held or recalled time for display
module lap_recorder
  import lap_recorder_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int HOLD_TICKS = 200
) (
  input  logic             clk_core,
  input  logic             rst,
  input  logic             clr_i,
  input  logic [7:0]       min_i,
  input  logic [7:0]       sec_i,
  input  logic [7:0]       ms_10_i,
  input  logic             lap_btn_i,
  input  logic             recall_btn_i,
  output logic [7:0]       disp_min_o,
  output logic [7:0]       disp_sec_o,
  output logic [7:0]       disp_ms_10_o,
  output logic [IDX_W-1:0] disp_idx_o,
  output logic [1:0]       mode_o,
  output logic [IDX_W-1:0] lap_cnt_o,
  output logic             full_o,
  output logic             lap_err_o
);
  localparam logic [IDX_W-1:0] DEPTH_L = IDX_W'(DEPTH);
  localparam logic [7:0]       HOLD_L  = 8'(HOLD_TICKS - 1);
  mode_t mode_q, mode_d;
  logic [IDX_W-1:0] lap_cnt_q, lap_cnt_d, wr_ptr_q, wr_ptr_d, rd_idx_q, rd_idx_d, idx_q, idx_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic err_q, err_d, lap_p, rec_p, full, we;
  lap_t disp_q, disp_d, live, rd_data;
  lap_t mem_q [DEPTH];
  btn_pulse u_lap (.clk_core(clk_core), .rst(rst), .btn_i(lap_btn_i), .pulse_o(lap_p));
  btn_pulse u_rec (.clk_core(clk_core), .rst(rst), .btn_i(recall_btn_i), .pulse_o(rec_p));
  assign live = {min_i, sec_i, ms_10_i};
  assign full = lap_cnt_q == DEPTH_L;
  always_comb begin
    mode_d     = mode_q;
    lap_cnt_d  = lap_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_idx_d   = rd_idx_q;
    hold_cnt_d = hold_cnt_q;
    err_d      = ~clr_i & lap_p & full;
    we         = ~clr_i & lap_p & ~full;
    rd_data    = '0;
    if (clr_i) begin
      mode_d    = LIVE;
      lap_cnt_d = '0;
      wr_ptr_d  = '0;
      rd_idx_d  = '0;
    end else begin
      if (we) begin
        lap_cnt_d = lap_cnt_q + 4'd1;
        wr_ptr_d  = wr_ptr_q + 4'd1;
      end
      if (mode_q == RECALL) begin
        if (rec_p) begin
          if (rd_idx_q == lap_cnt_q - 4'd1) mode_d = LIVE;
          else rd_idx_d = rd_idx_q + 4'd1;
        end
      end else if (we) begin
        mode_d     = HOLD;
        hold_cnt_d = HOLD_L;
      end else if (rec_p && lap_cnt_q != '0) begin
        mode_d   = RECALL;
        rd_idx_d = '0;
      end else if (mode_q == HOLD) begin
        if (hold_cnt_q == '0) mode_d = LIVE;
        else hold_cnt_d = hold_cnt_q - 8'd1;
      end
    end
    for (int i = 0; i < DEPTH; i++)
      if (rd_idx_d == IDX_W'(i)) rd_data = mem_q[i];
    disp_d = mode_d == RECALL ? rd_data : (mode_d == LIVE || we) ? live : disp_q;
    idx_d  = mode_d == RECALL ? rd_idx_d + 4'd1 : mode_d == LIVE ? '0 : we ? lap_cnt_d : idx_q;
  end
  always_ff @(posedge clk_core or negedge rst)
    if (!rst) begin
      mode_q     <= LIVE;
      lap_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_idx_q   <= '0;
      hold_cnt_q <= '0;
      err_q      <= 1'b0;
      disp_q     <= '0;
      idx_q      <= '0;
    end else begin
      mode_q     <= mode_d;
      lap_cnt_q  <= lap_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_idx_q   <= rd_idx_d;
      hold_cnt_q <= hold_cnt_d;
      err_q      <= err_d;
      disp_q     <= disp_d;
      idx_q      <= idx_d;
    end
  for (genvar g = 0; g < DEPTH; g++) begin : g_mem
    always_ff @(posedge clk_core)
      if (we && wr_ptr_q == IDX_W'(g)) mem_q[g] <= live;
  end
  assign {disp_min_o, disp_sec_o, disp_ms_10_o} = disp_q;
  assign disp_idx_o = idx_q;
  assign mode_o     = mode_q;
  assign lap_cnt_o  = lap_cnt_q;
  assign full_o     = full;
  assign lap_err_o  = err_q;
endmodule

// File: tb/tb_lap_recorder.sv
// tb_lap_recorder: directed self-checking bench for lap_recorder
module tb_lap_recorder;
  logic clk = 1'b0, rst = 1'b0, clr = 1'b0, lap = 1'b0, rec = 1'b0;
  logic [7:0] min = '0, sec = '0, ms = '0;
  logic [7:0] d_min, d_sec, d_ms;
  logic [3:0] d_idx, cnt;
  logic [1:0] mode;
  logic full, err;
  logic [29:0] view;
  logic [5:0] stat;
  int pass_cnt = 0, total = 0;
  lap_recorder #(.DEPTH(8), .HOLD_TICKS(200)) dut (
    .clk_core(clk), .rst(rst), .clr_i(clr), .min_i(min), .sec_i(sec), .ms_10_i(ms),
    .lap_btn_i(lap), .recall_btn_i(rec), .disp_min_o(d_min), .disp_sec_o(d_sec),
    .disp_ms_10_o(d_ms), .disp_idx_o(d_idx), .mode_o(mode), .lap_cnt_o(cnt),
    .full_o(full), .lap_err_o(err)
  );
  always #5 clk = ~clk;
  assign view = {mode, d_idx, d_min, d_sec, d_ms};
  assign stat = {cnt, full, err};
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_live(input logic [23:0] v);
    {min, sec, ms} = v;
  endtask
  task automatic press(input logic l, input logic r);
    lap = 1'b0;
    rec = 1'b0;
    tick();
    lap = l;
    rec = r;
    tick();
    lap = 1'b0;
    rec = 1'b0;
  endtask
  task automatic do_clr;
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask
  task automatic test_reset;
    lap = 1'b1;
    repeat (3) tick();
    total++; if (view !== 30'h0 || stat !== 6'h0) $display("FAIL reset_values view=%h stat=%h want 0/0", view, stat); else pass_cnt++;
    rst = 1'b1;
    repeat (3) tick();
    total++; if (view !== 30'h0 || stat !== 6'h0) $display("FAIL reset_held_lap view=%h stat=%h want 0/0", view, stat); else pass_cnt++;
    lap = 1'b0;
    tick();
  endtask
  task automatic test_hold;
    set_live(24'h012345);
    press(1'b1, 1'b0);
    total++; if (view !== {2'b01, 4'd1, 24'h012345}) $display("FAIL hold_capture got=%h want=%h", view, {2'b01, 4'd1, 24'h012345}); else pass_cnt++;
    total++; if (stat !== {4'd1, 1'b0, 1'b0}) $display("FAIL hold_count got=%h want=%h", stat, {4'd1, 2'b00}); else pass_cnt++;
    set_live(24'h020000);
    repeat (199) tick();
    total++; if (view !== {2'b01, 4'd1, 24'h012345}) $display("FAIL hold_last_cycle got=%h want=%h", view, {2'b01, 4'd1, 24'h012345}); else pass_cnt++;
    tick();
    total++; if (view !== {2'b00, 4'd0, 24'h020000}) $display("FAIL hold_expire got=%h want=%h", view, {2'b00, 4'd0, 24'h020000}); else pass_cnt++;
  endtask
  task automatic test_full;
    logic [3:0] k4;
    do_clr();
    total++; if (stat !== 6'h0) $display("FAIL full_clr got=%h want=0", stat); else pass_cnt++;
    for (int k = 1; k <= 8; k++) begin
      k4 = 4'(k);
      set_live({4'h0, k4, 4'h1, k4, 4'h2, k4});
      press(1'b1, 1'b0);
      total++; if (view !== {2'b01, k4, 4'h0, k4, 4'h1, k4, 4'h2, k4}) $display("FAIL full_lap%0d got=%h want=%h", k, view, {2'b01, k4, 4'h0, k4, 4'h1, k4, 4'h2, k4}); else pass_cnt++;
    end
    total++; if (stat !== {4'd8, 1'b1, 1'b0}) $display("FAIL full_flag got=%h want=%h", stat, {4'd8, 2'b10}); else pass_cnt++;
    set_live(24'h091929);
    press(1'b1, 1'b0);
    total++; if (stat !== {4'd8, 1'b1, 1'b1}) $display("FAIL full_err_pulse got=%h want=%h", stat, {4'd8, 2'b11}); else pass_cnt++;
    total++; if (view !== {2'b01, 4'd8, 24'h081828}) $display("FAIL full_reject_disp got=%h want=%h", view, {2'b01, 4'd8, 24'h081828}); else pass_cnt++;
    tick();
    total++; if (stat !== {4'd8, 1'b1, 1'b0}) $display("FAIL full_err_one_cycle got=%h want=%h", stat, {4'd8, 2'b10}); else pass_cnt++;
    for (int k = 1; k <= 8; k++) begin
      k4 = 4'(k);
      press(1'b0, 1'b1);
      total++; if (view !== {2'b10, k4, 4'h0, k4, 4'h1, k4, 4'h2, k4}) $display("FAIL full_recall%0d got=%h want=%h", k, view, {2'b10, k4, 4'h0, k4, 4'h1, k4, 4'h2, k4}); else pass_cnt++;
    end
    press(1'b0, 1'b1);
    total++; if (view !== {2'b00, 4'd0, 24'h091929}) $display("FAIL full_recall_exit got=%h want=%h", view, {2'b00, 4'd0, 24'h091929}); else pass_cnt++;
  endtask
  task automatic test_recall;
    logic [23:0] laps [3];
    laps = '{24'h123456, 24'h595999, 24'h000001};
    do_clr();
    press(1'b0, 1'b1);
    total++; if (view !== {2'b00, 4'd0, 24'h091929}) $display("FAIL recall_empty got=%h want=%h", view, {2'b00, 4'd0, 24'h091929}); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      set_live(laps[i]);
      press(1'b1, 1'b0);
    end
    set_live(24'h070809);
    for (int i = 0; i < 3; i++) begin
      press(1'b0, 1'b1);
      total++; if (view !== {2'b10, 4'(i + 1), laps[i]}) $display("FAIL recall_step%0d got=%h want=%h", i + 1, view, {2'b10, 4'(i + 1), laps[i]}); else pass_cnt++;
    end
    press(1'b0, 1'b1);
    total++; if (view !== {2'b00, 4'd0, 24'h070809}) $display("FAIL recall_wrap got=%h want=%h", view, {2'b00, 4'd0, 24'h070809}); else pass_cnt++;
  endtask
  task automatic test_simul;
    do_clr();
    set_live(24'h111111);
    press(1'b1, 1'b1);
    total++; if (view !== {2'b01, 4'd1, 24'h111111} || stat !== {4'd1, 2'b00}) $display("FAIL simul_live view=%h stat=%h want %h/%h", view, stat, {2'b01, 4'd1, 24'h111111}, {4'd1, 2'b00}); else pass_cnt++;
    set_live(24'h222222);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    total++; if (view !== {2'b10, 4'd1, 24'h111111}) $display("FAIL simul_enter_recall got=%h want=%h", view, {2'b10, 4'd1, 24'h111111}); else pass_cnt++;
    set_live(24'h333333);
    press(1'b1, 1'b1);
    total++; if (view !== {2'b10, 4'd2, 24'h222222} || stat !== {4'd3, 2'b00}) $display("FAIL simul_recall view=%h stat=%h want %h/%h", view, stat, {2'b10, 4'd2, 24'h222222}, {4'd3, 2'b00}); else pass_cnt++;
    press(1'b0, 1'b1);
    total++; if (view !== {2'b10, 4'd3, 24'h333333}) $display("FAIL simul_new_lap got=%h want=%h", view, {2'b10, 4'd3, 24'h333333}); else pass_cnt++;
    press(1'b0, 1'b1);
    total++; if (view !== {2'b00, 4'd0, 24'h333333}) $display("FAIL simul_exit got=%h want=%h", view, {2'b00, 4'd0, 24'h333333}); else pass_cnt++;
  endtask
  task automatic test_clear;
    do_clr();
    set_live(24'h444444);
    press(1'b1, 1'b0);
    tick();
    clr = 1'b1;
    lap = 1'b1;
    set_live(24'h555555);
    tick();
    clr = 1'b0;
    lap = 1'b0;
    total++; if (view !== {2'b00, 4'd0, 24'h555555} || stat !== 6'h0) $display("FAIL clr_hold view=%h stat=%h want %h/0", view, stat, {2'b00, 4'd0, 24'h555555}); else pass_cnt++;
    tick();
    total++; if (stat !== 6'h0) $display("FAIL clr_discard got=%h want=0", stat); else pass_cnt++;
    set_live(24'h666666);
    press(1'b1, 1'b0);
    set_live(24'h777777);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    total++; if (view !== {2'b10, 4'd1, 24'h666666}) $display("FAIL clr_pre_recall got=%h want=%h", view, {2'b10, 4'd1, 24'h666666}); else pass_cnt++;
    do_clr();
    total++; if (view !== {2'b00, 4'd0, 24'h777777} || stat !== 6'h0) $display("FAIL clr_recall view=%h stat=%h want %h/0", view, stat, {2'b00, 4'd0, 24'h777777}); else pass_cnt++;
    set_live(24'h888888);
    press(1'b1, 1'b0);
    total++; if (view !== {2'b01, 4'd1, 24'h888888} || stat !== {4'd1, 2'b00}) $display("FAIL clr_relap view=%h stat=%h want %h/%h", view, stat, {2'b01, 4'd1, 24'h888888}, {4'd1, 2'b00}); else pass_cnt++;
    set_live(24'h999999);
    press(1'b0, 1'b1);
    total++; if (view !== {2'b10, 4'd1, 24'h888888}) $display("FAIL clr_slot0 got=%h want=%h", view, {2'b10, 4'd1, 24'h888888}); else pass_cnt++;
  endtask
  initial begin
    test_reset();
    test_hold();
    test_full();
    test_recall();
    test_simul();
    test_clear();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/lap_recorder.md
Name: lap_recorder

Overview:
- Sits directly downstream of the stopwatch counting core, clocked by the same 100 Hz clk_core.
- Consumes the core's BCD minute, second and 10 ms values.
- On a lap button press, captures a split into a small lap memory and freezes the display for a hold period.
- On a recall button press, lets the user step through stored laps.
- Drives the display path with either the live time, the held split, or a recalled lap.

Parameters:
- DEPTH, 8, number of lap slots; legal range 1..15.
- HOLD_TICKS, 200, clk_core cycles the split stays frozen on the display (2 s at 100 Hz); legal range 1..255.

Ports:
- clk_core in 1: 100 Hz system tick clock.
- rst in 1: reset, asynchronous, active-low.
- clr_i in 1: synchronous lap-memory clear, active-high.
- min_i in 8: live minutes, BCD {tens,units}.
- sec_i in 8: live seconds, BCD.
- ms_10_i in 8: live hundredths, BCD.
- lap_btn_i in 1: lap button level, already synchronised.
- recall_btn_i in 1: recall button level, already synchronised.
- disp_min_o out 8: displayed minutes.
- disp_sec_o out 8: displayed seconds.
- disp_ms_10_o out 8: displayed hundredths.
- disp_idx_o out 4: lap number shown; 0 means live time.
- mode_o out 2: current state; 00 LIVE, 01 HOLD, 10 RECALL.
- lap_cnt_o out 4: number of stored laps.
- full_o out 1: lap_cnt_o == DEPTH.
- lap_err_o out 1: one-cycle pulse when a lap is rejected because the memory is full.

Behaviour:
- Reset values: all disp_* = 0, disp_idx_o = 0, mode_o = LIVE, lap_cnt_o = 0, full_o = 0, lap_err_o = 0, wr_ptr = 0, rd_idx = 0, hold_cnt = 0. Lap memory contents are don't-care.
- Edge detect: the previous-level register of each button resets to 1, so a button held through reset release produces no pulse. A pulse is a 0->1 transition between consecutive clk_core edges; it lasts one cycle.
- Capture: the stored triple is {min_i, sec_i, ms_10_i} as sampled on the edge where the lap pulse is seen.
- Accepted lap (lap_cnt < DEPTH): mem[wr_ptr] <= triple, wr_ptr++, lap_cnt++.
- Rejected lap (lap_cnt == DEPTH): no write; lap_err_o = 1 for the next cycle only.
- All display outputs are registered with 1-cycle latency from the selecting edge.
- LIVE:
  - disp = live inputs; disp_idx = 0.
  - Accepted lap -> HOLD, hold_cnt = HOLD_TICKS-1, disp = captured triple, disp_idx = new lap_cnt.
  - Rejected lap -> stays LIVE.
  - Recall pulse with lap_cnt > 0 -> RECALL, rd_idx = 0. With lap_cnt == 0 it is ignored.
- HOLD:
  - disp frozen; hold_cnt decrements each cycle; when it is 0 on a cycle, -> LIVE next.
  - Accepted lap: capture, reload hold_cnt, update disp and disp_idx.
  - Rejected lap: error pulse only; the hold timer continues.
  - Recall pulse -> RECALL, rd_idx = 0.
- RECALL:
  - disp = mem[rd_idx]; disp_idx = rd_idx+1.
  - Recall pulse: if rd_idx == lap_cnt-1 -> LIVE; otherwise rd_idx++.
  - A lap pulse still records (or errors) and the state stays RECALL; the newly stored lap becomes reachable by stepping.
- Simultaneous lap and recall pulses:
  - In LIVE or HOLD, the lap is processed and recall is ignored.
  - In RECALL, both are processed.
- clr_i has the highest priority after rst. It sets lap_cnt = 0, wr_ptr = 0, rd_idx = 0, full_o = 0 and state = LIVE in any state, and discards any same-cycle button pulses.
- The BCD values are not checked or modified; they pass through bit-exact.

Decomposition:
- Shared package:
  - Mode encodings LIVE/HOLD/RECALL.
  - 24-bit lap-record typedef {min,sec,ms_10}.
  - Index width constant 4.
- One sub-module, btn_pulse: a previous-level register with reset value 1 producing a 0->1 pulse. It is instantiated twice.

Test Plan:
1. Reset release with lap_btn_i held high -> no capture; lap_cnt_o = 0 and mode_o = 00.
2. Live input 01:23.45, lap press -> next cycle mode_o = 01, disp = 01/23/45, disp_idx_o = 1; after exactly HOLD_TICKS cycles mode_o = 00 and disp tracks the live inputs.
3. With DEPTH = 8, nine lap presses -> lap_cnt_o = 8, full_o = 1, and a single-cycle lap_err_o on the 9th press; mem[7] is unchanged.
4. Three stored laps, four recall presses -> disp_idx_o steps 1, 2, 3, then 0 with mode_o = 00; each display matches the value captured for that lap.
5. Lap and recall pressed in the same cycle in LIVE -> lap stored, mode_o = HOLD; the same in RECALL -> lap stored and rd_idx advanced.
6. clr_i asserted during HOLD and during RECALL -> next cycle lap_cnt_o = 0, mode_o = 00, disp_idx_o = 0; a subsequent lap is written to slot 0.
